// File: rtl/pwm_bank_ctrl_if.sv
// rtl/pwm_bank_ctrl_if.sv - SPI byte-side bus between the SPI slave and pwm_bank_ctrl
interface pwm_bank_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_abort;
    logic [7:0] tx_data;
    logic       tx_load;

    modport master (
        output rx_data, rx_valid, frame_abort,
        input  tx_data, tx_load
    );

    modport slave (
        input  rx_data, rx_valid, frame_abort,
        output tx_data, tx_load
    );
endinterface

// File: rtl/pwm_bank_ctrl.sv
// rtl/pwm_bank_ctrl.sv - SPI command sequencer and shadow/active register bank for PWM channels
module pwm_bank_ctrl #(
    parameter int NCH = 7,
    parameter int DW  = 16
) (
    input  logic               sys_clk,
    input  logic               rst,
    pwm_bank_ctrl_if.slave     bus,
    input  logic               cnt_wrap,
    output logic [NCH*DW-1:0]  duty_active,
    output logic [NCH-1:0]     ch_en,
    output logic               cmd_err,
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, RD_HI, RD_LO} state_t;

    state_t state, state_nxt;

    logic [2:0]     cmd_ch;
    logic [1:0]     cmd_reg;
    logic           cmd_ok;
    logic [7:0]     hi_byte;
    logic [7:0]     tx_data_q;
    logic           tx_load_q;
    logic [DW-1:0]  shadow_duty [NCH];
    logic [DW-1:0]  active_duty [NCH];
    logic [NCH-1:0] shadow_en;
    logic [NCH-1:0] active_en;
    logic [NCH-1:0] pending;
    logic [6:0]     pend7;

    logic           accept, cmd_fire, wr_fire;
    logic           rx_wr, rx_err;
    logic [2:0]     rx_ch, sel_ch;
    logic [1:0]     rx_reg, sel_reg;
    logic           sel_ok;
    logic [DW-1:0]  rd_word;
    logic           unused_bits;

    assign unused_bits = ^bus.rx_data[6:5];

    assign rx_wr  = bus.rx_data[7];
    assign rx_ch  = bus.rx_data[4:2];
    assign rx_reg = bus.rx_data[1:0];
    // Reserved reg, status writes and out-of-range channels are all flagged.
    assign rx_err = (rx_reg == 2'b10)
                 || (rx_reg != 2'b11 && {1'b0, rx_ch} >= 4'(NCH))
                 || (rx_wr && rx_reg == 2'b11);

    assign accept   = bus.rx_valid && !bus.frame_abort;
    assign cmd_fire = accept && (state == IDLE);
    assign wr_fire  = accept && (state == WR_LO) && cmd_ok;

    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.frame_abort) begin
            state_nxt = IDLE;
        end else if (bus.rx_valid) begin
            case (state)
                IDLE:    state_nxt = rx_wr ? WR_HI : RD_HI;
                WR_HI:   state_nxt = WR_LO;
                RD_HI:   state_nxt = RD_LO;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        pend7 = '0;
        pend7[NCH-1:0] = pending;
    end

    // In IDLE the incoming command selects the register; afterwards the latched one does.
    assign sel_ch  = (state == IDLE) ? rx_ch  : cmd_ch;
    assign sel_reg = (state == IDLE) ? rx_reg : cmd_reg;
    assign sel_ok  = (state == IDLE) ? !rx_err : cmd_ok;

    always_comb begin
        rd_word = '0;
        if (sel_ok) begin
            case (sel_reg)
                2'b00: begin
                    for (int i = 0; i < NCH; i++)
                        if (sel_ch == 3'(i)) rd_word = active_duty[i];
                end
                2'b01: begin
                    for (int i = 0; i < NCH; i++)
                        if (sel_ch == 3'(i)) rd_word = {{(DW-1){1'b0}}, active_en[i]};
                end
                2'b11:   rd_word = {cmd_err, 7'b0, 1'b0, pend7};
                default: rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cmd_ch    <= '0;
            cmd_reg   <= '0;
            cmd_ok    <= 1'b0;
            hi_byte   <= '0;
            tx_data_q <= '0;
            tx_load_q <= 1'b0;
            cmd_err   <= 1'b0;
            shadow_en <= '0;
            active_en <= '0;
            pending   <= '0;
            for (int i = 0; i < NCH; i++) begin
                shadow_duty[i] <= '0;
                active_duty[i] <= '0;
            end
        end else begin
            tx_load_q <= 1'b0;
            if (cmd_fire) begin
                cmd_ch  <= rx_ch;
                cmd_reg <= rx_reg;
                cmd_ok  <= !rx_err;
                if (rx_err) cmd_err <= 1'b1;
                if (!rx_wr) begin
                    tx_data_q <= rd_word[15:8];
                    tx_load_q <= 1'b1;
                    if (rx_reg == 2'b11) cmd_err <= 1'b0;
                end
            end
            if (accept && state == WR_HI) hi_byte <= bus.rx_data;
            if (accept && state == RD_HI) begin
                tx_data_q <= rd_word[7:0];
                tx_load_q <= 1'b1;
            end
            // A write landing on the wrap edge stays pending until the next wrap.
            for (int i = 0; i < NCH; i++) begin
                if (wr_fire && cmd_ch == 3'(i)) begin
                    if (cmd_reg == 2'b00) shadow_duty[i] <= {hi_byte, bus.rx_data};
                    else                  shadow_en[i]   <= bus.rx_data[0];
                    pending[i] <= 1'b1;
                end else if (cnt_wrap && pending[i]) begin
                    active_duty[i] <= shadow_duty[i];
                    active_en[i]   <= shadow_en[i];
                    pending[i]     <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) duty_active[i*DW +: DW] = active_duty[i];
    end

    assign ch_en       = active_en;
    assign busy        = (state != IDLE);
    assign bus.tx_data = tx_data_q;
    assign bus.tx_load = tx_load_q;

endmodule
